intr_latch_hub: RTL and testbench
=================================

INTR_LATCH_HUB -- requirements
Module: intr_latch_hub

Interface
REQ-001 The block SHALL have parameter NUM_INT, default 8, giving the number of pulse sources (1..32).
REQ-002 The block SHALL have parameter GAP_CYC, default 4, giving the minimum irq_o low time between assertions (0..255).
REQ-003 clk  input  1  clock; all logic SHALL be rising-edge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 int_pulse_i  input  NUM_INT  single-cycle interrupt event pulses, one per source.
REQ-006 wr_en  input  1  register write strobe, one cycle per write.
REQ-007 wr_addr  input  2  write register address.
REQ-008 wr_data  input  32  write data; bits above NUM_INT-1 SHALL be ignored.
REQ-009 rd_en  input  1  register read strobe.
REQ-010 rd_addr  input  2  read register address.
REQ-011 rd_data  output  32  read data; unused upper bits SHALL read 0.
REQ-012 rd_valid  output  1  rd_data valid, one cycle.
REQ-013 irq_o  output  1  registered level interrupt to host.

Function
REQ-014 Register map SHALL be: 0 PENDING (read; write-1-to-clear); 1 MASK (read/write, 1 = enabled); 2 ACTIVE (read-only, PENDING & MASK); 3 LOSTCNT (see Configuration).
REQ-015 A high int_pulse_i[k] in cycle n SHALL set PENDING[k] visible from cycle n+1, regardless of MASK[k].
REQ-016 A write to addr 0 SHALL clear every PENDING bit whose wr_data bit is 1; other bits SHALL be unchanged.
REQ-017 A pulse and a W1C clear on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-018 Writes to addr 2 and addr 3 SHALL have no effect.
REQ-019 Read latency: rd_en in cycle n SHALL produce rd_valid=1 and rd_data in cycle n+1, reflecting register values at the end of cycle n, before any same-cycle update.
REQ-020 rd_valid SHALL be 0 in every cycle not following an rd_en.
REQ-021 The irq FSM SHALL have states IDLE, ASSERT and GAP, with irq_o = 1 only in ASSERT.
REQ-022 IDLE -> ASSERT SHALL occur when ACTIVE != 0; a pulse in cycle n on an unmasked, clear bit SHALL give irq_o=1 in cycle n+2.
REQ-023 ASSERT -> GAP SHALL occur when ACTIVE == 0, whether by W1C or by a MASK write; the gap counter SHALL load GAP_CYC.
REQ-024 GAP SHALL hold irq_o=0 for exactly GAP_CYC cycles, then go to IDLE; with GAP_CYC=0, ASSERT SHALL go directly to IDLE.
REQ-025 In GAP, new ACTIVE bits SHALL stay pending and SHALL NOT shorten the gap.
REQ-026 irq_o SHALL stay high while any ACTIVE bit remains set, including bits newly set during ASSERT.

Reset
REQ-027 With rst=0 at a clk edge: PENDING=0, MASK=0, LOSTCNT=0, FSM=IDLE, irq_o=0, rd_valid=0, rd_data=0.
REQ-028 While rst=0, pulses, writes and reads SHALL be ignored.
REQ-029 Reset asserted mid-ASSERT or mid-GAP SHALL drop irq_o to 0 on the next edge, with no gap enforced after release.

Configuration
REQ-030 Macro INTR_HUB_LOSTCNT_EN SHALL control the lost-event counter.
REQ-031 With INTR_HUB_LOSTCNT_EN defined, LOSTCNT (8 bits) SHALL increment once per cycle in which any pulse arrives on a bit already set in PENDING.
REQ-032 With the macro defined, LOSTCNT SHALL saturate at 255 and clear to 0 in the cycle after it is read.
REQ-033 A read of LOSTCNT SHALL return the pre-clear value; a lost event in the read cycle SHALL count toward the cleared value, giving 1.
REQ-034 Without the macro, no counter logic SHALL exist and addr 3 SHALL read 0.

Verification
REQ-035 MASK=0x01, pulse bit0 at cycle 10 -> PENDING=0x01 at 11, irq_o=1 at 12.
REQ-036 MASK=0x00, pulse bit3 -> PENDING=0x08, irq_o stays 0; write MASK=0x08 -> irq_o=1 two cycles later.
REQ-037 irq asserted on bit0, GAP_CYC=4: W1C 0x01 plus pulse bit1 (MASK=0x03) during GAP -> irq_o low exactly 4 cycles, then IDLE, then high on the next cycle.
REQ-038 Same-cycle W1C 0x04 and pulse bit2 -> PENDING[2]=1 and irq_o remains 1.
REQ-039 With INTR_HUB_LOSTCNT_EN: 3 pulses on bit5 with no clear -> LOSTCNT reads 2, then reads 0; 300 repeats -> reads 255.
REQ-040 rst=0 during ASSERT with PENDING=0xFF -> next cycle irq_o=0 and PENDING=0; release rst -> irq_o stays 0 until MASK is written.

Source files
------------

// File: rtl/intr_latch_hub.sv
// Pulse-to-level interrupt hub: PENDING/MASK/ACTIVE registers and an irq FSM with a minimum low gap.
// Optional lost-event counter on register 3 is built when INTR_HUB_LOSTCNT_EN is defined.
module intr_latch_hub #(
  parameter int unsigned NUM_INT = 8,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] int_pulse_i,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               rd_en,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               irq_o
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [NUM_INT-1:0] r_pending;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] w_active;
  logic [NUM_INT-1:0] w_clr;
  logic [DATA_W-1:0]  w_lost_word;
  logic [DATA_W-1:0]  w_rd_word;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;
  logic               r_irq;
  logic [GAP_W-1:0]   r_gap_cnt;
  state_t             r_state;
  logic               w_unused_wr;

  // Bits of wr_data above NUM_INT-1 are intentionally dropped.
  assign w_unused_wr = ^wr_data;

  assign w_active = r_pending & r_mask;
  assign w_clr    = (wr_en && (wr_addr == 2'd0)) ? wr_data[NUM_INT-1:0] : '0;

  // Pulses are OR'd in after the clear so a coincident pulse wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | int_pulse_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= '0;
    end else if (wr_en && (wr_addr == 2'd1)) begin
      r_mask <= wr_data[NUM_INT-1:0];
    end
  end

`ifdef INTR_HUB_LOSTCNT_EN
  logic [7:0] r_lostcnt;
  logic       w_lost;
  logic       w_lost_rd;

  assign w_lost    = |(int_pulse_i & r_pending);
  assign w_lost_rd = rd_en && (rd_addr == 2'd3);

  // Read-to-clear; a loss in the read cycle seeds the fresh count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lostcnt <= '0;
    end else if (w_lost_rd) begin
      r_lostcnt <= w_lost ? 8'd1 : 8'd0;
    end else if (w_lost && (r_lostcnt != 8'hFF)) begin
      r_lostcnt <= r_lostcnt + 8'd1;
    end
  end

  assign w_lost_word = DATA_W'(r_lostcnt);
`else
  assign w_lost_word = '0;
`endif

  always_comb begin
    w_rd_word = '0;
    case (rd_addr)
      2'd0:    w_rd_word = DATA_W'(r_pending);
      2'd1:    w_rd_word = DATA_W'(r_mask);
      2'd2:    w_rd_word = DATA_W'(w_active);
      default: w_rd_word = w_lost_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  // irq FSM: irq stays low for GAP_CYC cycles after every deassertion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_irq     <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_active != '0) begin
            r_state <= ASSERT;
            r_irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (w_active == '0) begin
            r_irq <= 1'b0;
            if (GAP_LOAD == '0) begin
              r_state <= IDLE;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt <= GAP_W'(1)) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_intr_latch_hub.sv
// Directed self-checking bench for intr_latch_hub (NUM_INT=8, GAP_CYC=4).
module tb_intr_latch_hub;
  localparam int unsigned NUM_INT = 8;
  localparam int unsigned GAP_CYC = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_INT-1:0] int_pulse_i = '0;
  logic               wr_en = 1'b0;
  logic [1:0]         wr_addr = '0;
  logic [31:0]        wr_data = '0;
  logic               rd_en = 1'b0;
  logic [1:0]         rd_addr = '0;
  logic [31:0]        rd_data;
  logic               rd_valid;
  logic               irq_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rdv;
  logic        vld;

  intr_latch_hub #(.NUM_INT(NUM_INT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .int_pulse_i(int_pulse_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    rd_en = 1'b1; rd_addr = a;
    tick();
    d = rd_data; v = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_INT-1:0] b);
    int_pulse_i = b;
    tick();
    int_pulse_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; int_pulse_i = '1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = '1; rd_en = 1'b1;
    tick(); tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_o); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else n_pass++;
    int_pulse_i = '0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    rst = 1'b1;
    tick();
    do_read(2'd1, rdv, vld);
    n_checks++; if (rdv !== 32'h0 || vld !== 1'b1) $display("FAIL reset_mask: got %h/%b want 0/1", rdv, vld); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h0) $display("FAIL reset_pending: got %h want 0", rdv); else n_pass++;
  endtask

  task automatic test_basic();
    do_write(2'd1, 32'h1);
    int_pulse_i = 8'h01;
    tick();
    int_pulse_i = '0; rd_en = 1'b1; rd_addr = 2'd0;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL basic_irq_n1: got %b want 0", irq_o); else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h1) $display("FAIL basic_pending: got %h/%b want 1/1", rd_data, rd_valid); else n_pass++;
    n_checks++; if (irq_o !== 1'b1) $display("FAIL basic_irq_n2: got %b want 1", irq_o); else n_pass++;
    do_read(2'd2, rdv, vld);
    n_checks++; if (rdv !== 32'h1) $display("FAIL basic_active: got %h want 1", rdv); else n_pass++;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL basic_rd_valid_idle: got %b want 0", rd_valid); else n_pass++;
  endtask

  task automatic test_gap();
    do_write(2'd1, 32'h3);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h1;
    tick();
    wr_en = 1'b0; wr_data = '0;
    n_checks++; if (irq_o !== 1'b1) $display("FAIL gap_irq_before: got %b want 1", irq_o); else n_pass++;
    int_pulse_i = 8'h02;
    tick();
    int_pulse_i = '0;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL gap_low0: got %b want 0", irq_o); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (irq_o !== 1'b0) $display("FAIL gap_low%0d: got %b want 0", k, irq_o); else n_pass++;
    end
    tick();
    n_checks++; if (irq_o !== 1'b1) $display("FAIL gap_reassert: got %b want 1", irq_o); else n_pass++;
  endtask

  task automatic test_set_wins();
    do_write(2'd1, 32'h7);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h4; int_pulse_i = 8'h04;
    tick();
    wr_en = 1'b0; wr_data = '0; int_pulse_i = '0;
    do_write(2'd0, 32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (irq_o !== 1'b1) $display("FAIL setwins_irq%0d: got %b want 1", k, irq_o); else n_pass++;
    end
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h4) $display("FAIL setwins_pending: got %h want 4", rdv); else n_pass++;
  endtask

  task automatic test_mask_deassert();
    do_write(2'd1, 32'h0);
    n_checks++; if (irq_o !== 1'b1) $display("FAIL maskoff_irq_n1: got %b want 1", irq_o); else n_pass++;
    tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL maskoff_irq_n2: got %b want 0", irq_o); else n_pass++;
    do_read(2'd2, rdv, vld);
    n_checks++; if (rdv !== 32'h0) $display("FAIL maskoff_active: got %h want 0", rdv); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h4) $display("FAIL maskoff_pending: got %h want 4", rdv); else n_pass++;
    do_write(2'd0, 32'hFF);
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_masked();
    pulse(8'h08);
    tick(); tick(); tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL masked_irq: got %b want 0", irq_o); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h8) $display("FAIL masked_pending: got %h want 8", rdv); else n_pass++;
    do_write(2'd1, 32'hFFFF_FF08);
    n_checks++; if (irq_o !== 1'b0) $display("FAIL unmask_irq_n1: got %b want 0", irq_o); else n_pass++;
    tick();
    n_checks++; if (irq_o !== 1'b1) $display("FAIL unmask_irq_n2: got %b want 1", irq_o); else n_pass++;
    do_write(2'd2, 32'hFFFF_FFFF);
    do_write(2'd3, 32'hFFFF_FFFF);
    do_read(2'd1, rdv, vld);
    n_checks++; if (rdv !== 32'h8) $display("FAIL ro_write_mask: got %h want 8", rdv); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h8) $display("FAIL ro_write_pending: got %h want 8", rdv); else n_pass++;
  endtask

  task automatic test_read_timing();
    rd_en = 1'b1; rd_addr = 2'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h8;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    n_checks++; if (rd_data !== 32'h8 || rd_valid !== 1'b1) $display("FAIL rd_preclear: got %h/%b want 8/1", rd_data, rd_valid); else n_pass++;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_drop: got %b want 0", rd_valid); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h0) $display("FAIL rd_postclear: got %h want 0", rdv); else n_pass++;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_lostcnt();
    do_write(2'd0, 32'hFF);
    pulse(8'h20); pulse(8'h20); pulse(8'h20);
`ifdef INTR_HUB_LOSTCNT_EN
    do_read(2'd3, rdv, vld);
    n_checks++; if (rdv !== 32'd2) $display("FAIL lost_two: got %0d want 2", rdv); else n_pass++;
    do_read(2'd3, rdv, vld);
    n_checks++; if (rdv !== 32'd0) $display("FAIL lost_cleared: got %0d want 0", rdv); else n_pass++;
    int_pulse_i = 8'h20;
    for (int k = 0; k < 300; k++) tick();
    int_pulse_i = '0;
    do_read(2'd3, rdv, vld);
    n_checks++; if (rdv !== 32'd255) $display("FAIL lost_sat: got %0d want 255", rdv); else n_pass++;
    rd_en = 1'b1; rd_addr = 2'd3; int_pulse_i = 8'h20;
    tick();
    rd_en = 1'b0; int_pulse_i = '0;
    n_checks++; if (rd_data !== 32'd0) $display("FAIL lost_rd_same: got %0d want 0", rd_data); else n_pass++;
    do_read(2'd3, rdv, vld);
    n_checks++; if (rdv !== 32'd1) $display("FAIL lost_seed: got %0d want 1", rdv); else n_pass++;
`else
    do_read(2'd3, rdv, vld);
    n_checks++; if (rdv !== 32'd0 || vld !== 1'b1) $display("FAIL lost_absent: got %0d/%b want 0/1", rdv, vld); else n_pass++;
`endif
    do_write(2'd0, 32'hFF);
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset_mid();
    do_write(2'd1, 32'hFF);
    pulse(8'hFF);
    tick();
    n_checks++; if (irq_o !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", irq_o); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq_o); else n_pass++;
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_ignored: got %b want 0", rd_valid); else n_pass++;
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL rstmid_release: got %b want 0", irq_o); else n_pass++;
    do_read(2'd0, rdv, vld);
    n_checks++; if (rdv !== 32'h0) $display("FAIL rstmid_pending: got %h want 0", rdv); else n_pass++;
    do_read(2'd1, rdv, vld);
    n_checks++; if (rdv !== 32'h0) $display("FAIL rstmid_mask: got %h want 0", rdv); else n_pass++;
    pulse(8'h01);
    tick(); tick();
    n_checks++; if (irq_o !== 1'b0) $display("FAIL rstmid_masked: got %b want 0", irq_o); else n_pass++;
    do_write(2'd1, 32'h1);
    n_checks++; if (irq_o !== 1'b0) $display("FAIL rstmid_unmask_n1: got %b want 0", irq_o); else n_pass++;
    tick();
    n_checks++; if (irq_o !== 1'b1) $display("FAIL rstmid_unmask_n2: got %b want 1", irq_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_set_wins();
    test_mask_deassert();
    test_masked();
    test_read_timing();
    test_lostcnt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
